// File: rtl/regfile_wr_arb.sv
// ---------------------------------------------------------------------------
// regfile_wr_arb
//   Round-robin arbiter and sequencer for the single write port of the 32x8
//   register file. Up to NREQ requesters each offer one write. One write is
//   granted per cycle and is registered onto we/dst/data. A granted requester
//   may lock the port for a multi-write burst. A watchdog bounds how long a
//   lock can be held.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   [NREQ]       requester i offers a write
//   req_dst    in   [NREQ*AW]    destination of requester i, slice [i*AW +: AW]
//   req_data   in   [NREQ*DW]    data of requester i, slice [i*DW +: DW]
//   req_lock   in   [NREQ]       keep the grant after this transfer
//   req_ready  out  [NREQ]       one-hot or zero; transfer on valid & ready
//   we         out  register file write enable
//   dst        out  [AW]         register file write address
//   data       out  [DW]         register file write data
//   grant_id   out  [2]          requester whose write is on we/dst/data
//   locked     out  port is locked to grant_id
//   lock_err   out  one-cycle pulse when the watchdog forces a release
// ---------------------------------------------------------------------------
module regfile_wr_arb #(
    parameter int NREQ     = 3,
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_dst,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we,
    output logic [AW-1:0]        dst,
    output logic [DW-1:0]        data,
    output logic [1:0]           grant_id,
    output logic                 locked,
    output logic                 lock_err
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr;
    logic [7:0]  cnt, cnt_nxt;
    logic        lock_err_nxt;

    logic        win_found;
    logic [1:0]  win_id;
    logic [1:0]  idx;
    logic [1:0]  sel_p0;
    logic        xfer_p0;

    // Saturating 8-bit increment for the lock-length counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) return v;
        return v + 8'd1;
    endfunction

    // Round-robin search: first valid requester after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = 2'((int'(ptr) + k) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Ready generation and next-state logic.
    always_comb begin
        req_ready    = '0;
        sel_p0       = win_id;
        xfer_p0      = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        lock_err_nxt = 1'b0;
        case (state)
            ARB: begin
                cnt_nxt = '0;
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    xfer_p0           = 1'b1;
                    if (req_lock[win_id]) begin
                        state_nxt = LOCK;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            LOCK: begin
                sel_p0 = grant_id;
                if (!req_valid[grant_id]) begin
                    // Owner abandoned the burst; this takes priority over the watchdog.
                    state_nxt = ARB;
                    cnt_nxt   = '0;
                end else begin
                    req_ready[grant_id] = 1'b1;
                    xfer_p0             = 1'b1;
                    if (!req_lock[grant_id]) begin
                        state_nxt = ARB;
                        cnt_nxt   = '0;
                    end else if (int'(cnt) >= LOCK_MAX - 1) begin
                        // This locked write is the LOCK_MAX-th of the burst: accept it, then force release.
                        state_nxt    = ARB;
                        cnt_nxt      = '0;
                        lock_err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = sat_inc8(cnt);
                    end
                end
            end
            default: begin
                state_nxt = ARB;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            ptr      <= 2'(NREQ - 1);
            cnt      <= '0;
            lock_err <= 1'b0;
            we       <= 1'b0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lock_err <= lock_err_nxt;
            we       <= xfer_p0;
            if (xfer_p0) begin
                ptr      <= sel_p0;
                grant_id <= sel_p0;
            end
        end
    end

    // ---- stage boundary: granted write registered onto the register-file port ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst  <= '0;
            data <= '0;
        end else if (xfer_p0) begin
            dst  <= req_dst[int'(sel_p0)*AW +: AW];
            data <= req_data[int'(sel_p0)*DW +: DW];
        end
    end

    assign locked = (state == LOCK);

endmodule
